// File: rtl/ic1406_driver.sv
// ic1406_driver: steers an ic1406 two-flip-flop unit to a requested {Q1,Q0} and parks it there.
// Optional consistency check of shadow state vs. unit outputs: define IC1406_DRIVER_CHECK_EN.
module ic1406_driver (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] target,
  output logic       A0,
  output logic       A1,
  output logic       A2,
  input  logic       Q0_obs,
  input  logic       Q1_obs,
  input  logic       Z_obs,
  output logic [1:0] state,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // state   | meaning
  // IDLE    | park the unit on its current state, wait for start
  // SYNC    | unit is forced to 11 at this edge
  // STEP1   | unit passes through 01 (target 00 only)
  // STEP2   | unit reaches target
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_STEP1, S_STEP2} fsm_t;

  fsm_t       r_fsm, w_fsm_nxt;
  logic [1:0] r_tgt;
  logic [1:0] r_state, w_state_nxt;
  logic [2:0] r_code, w_code_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;

  function automatic logic [1:0] f_step(input logic [1:0] s, input logic [2:0] c);
    case (c)
      3'b000, 3'b001, 3'b010: f_step = {~s[1], 1'b1};
      3'b011:                 f_step = {s[1], ~s[0]};
      3'b100:                 f_step = {1'b1, s[0]};
      3'b101, 3'b110:         f_step = 2'b11;
      default:                f_step = {s[1], 1'b1};
    endcase
  endfunction

  // 00 cannot be held; 111 moves it to 01, which 111 then holds
  function automatic logic [2:0] f_park(input logic [1:0] s);
    case (s)
      2'b11:   f_park = 3'b101;
      2'b10:   f_park = 3'b100;
      default: f_park = 3'b111;
    endcase
  endfunction

  assign w_state_nxt = f_step(r_state, r_code);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= S_IDLE;
      r_tgt <= 2'b11;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (r_fsm == S_IDLE && start) r_tgt <= target;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (start) w_fsm_nxt = S_SYNC;
      S_SYNC: begin
        case (r_tgt)
          2'b11:   w_fsm_nxt = S_IDLE;
          2'b00:   w_fsm_nxt = S_STEP1;
          default: w_fsm_nxt = S_STEP2;
        endcase
      end
      S_STEP1: w_fsm_nxt = S_STEP2;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_code_nxt = f_park(w_state_nxt);
    case (r_fsm)
      S_IDLE:  if (start) w_code_nxt = 3'b101;
      S_SYNC: begin
        if (r_tgt == 2'b10)      w_code_nxt = 3'b011;
        else if (r_tgt != 2'b11) w_code_nxt = 3'b000;
      end
      S_STEP1: w_code_nxt = 3'b011;
      default: w_code_nxt = f_park(w_state_nxt);
    endcase
    w_busy_nxt = (w_fsm_nxt != S_IDLE);
    w_done_nxt = (r_fsm != S_IDLE) && (w_fsm_nxt == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_code  <= 3'b101;
      r_state <= 2'b11;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_code  <= w_code_nxt;
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign {A2, A1, A0} = r_code;
  assign state        = r_state;
  assign busy         = r_busy;
  assign done         = r_done;

`ifdef IC1406_DRIVER_CHECK_EN
  logic r_check_valid;
  logic r_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_check_valid <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_check_valid <= 1'b1;
      if (r_check_valid &&
          (({Q1_obs, Q0_obs} != r_state) || (Z_obs != (r_state[1] ^ r_state[0]))))
        r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  logic w_unused_obs;
  assign w_unused_obs = ^{Q0_obs, Q1_obs, Z_obs};
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_ic1406_driver.sv
// Directed bench for ic1406_driver with a behavioural ic1406 unit on the observe inputs.
module tb_ic1406_driver;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] target;
  logic       A0, A1, A2;
  logic       Q0_obs, Q1_obs, Z_obs;
  logic [1:0] state;
  logic       busy, done, error;

  int n_cmp = 0;
  int n_err = 0;

  logic u_q1 = 1'b0, u_q0 = 1'b0;
  logic force_q1_low = 1'b0;

  ic1406_driver dut (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .A0(A0), .A1(A1), .A2(A2),
    .Q0_obs(Q0_obs), .Q1_obs(Q1_obs), .Z_obs(Z_obs),
    .state(state), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // unit model: per-code effect on each flip-flop
  always @(posedge clk) begin
    case ({A2, A1, A0})
      3'b000, 3'b001, 3'b010: begin u_q1 <= ~u_q1; u_q0 <= 1'b1;  end
      3'b011:                 begin u_q1 <= u_q1;  u_q0 <= ~u_q0; end
      3'b100:                 begin u_q1 <= 1'b1;  u_q0 <= u_q0;  end
      3'b111:                 begin u_q1 <= u_q1;  u_q0 <= 1'b1;  end
      default:                begin u_q1 <= 1'b1;  u_q0 <= 1'b1;  end
    endcase
  end

  assign Q1_obs = force_q1_low ? 1'b0 : u_q1;
  assign Q0_obs = u_q0;
  assign Z_obs  = u_q1 ^ u_q0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] a, input logic [1:0] st,
                         input logic bsy, input logic dn);
    chk({tag, ".A"},     {5'd0, A2, A1, A0}, {5'd0, a});
    chk({tag, ".state"}, {6'd0, state},      {6'd0, st});
    chk({tag, ".busy"},  {7'd0, busy},       {7'd0, bsy});
    chk({tag, ".done"},  {7'd0, done},       {7'd0, dn});
    chk({tag, ".error"}, {7'd0, error},      8'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target = 2'b00;
    tick(); tick();
    chk_all("reset", 3'b101, 2'b11, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("idle", 3'b101, 2'b11, 1'b0, 1'b0);
    end

    // target 11 from 11: done one edge after accept
    start = 1'b1; target = 2'b11;
    tick(); start = 1'b0;
    chk_all("t11.E", 3'b101, 2'b11, 1'b1, 1'b0);
    tick(); chk_all("t11.E1", 3'b101, 2'b11, 1'b0, 1'b1);
    tick(); chk_all("t11.post", 3'b101, 2'b11, 1'b0, 1'b0);

    // target 10
    start = 1'b1; target = 2'b10;
    tick(); start = 1'b0; target = 2'b01;
    chk_all("t10.E", 3'b101, 2'b11, 1'b1, 1'b0);
    tick(); chk_all("t10.E1", 3'b011, 2'b11, 1'b1, 1'b0);
    tick(); chk_all("t10.E2", 3'b100, 2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("t10.hold", 3'b100, 2'b10, 1'b0, 1'b0);
    end

    // target 00 from parked 10
    start = 1'b1; target = 2'b00;
    tick(); start = 1'b0; target = 2'b11;
    chk_all("t00.E", 3'b101, 2'b10, 1'b1, 1'b0);
    tick(); chk_all("t00.E1", 3'b000, 2'b11, 1'b1, 1'b0);
    tick(); chk_all("t00.E2", 3'b011, 2'b01, 1'b1, 1'b0);
    tick(); chk_all("t00.E3", 3'b111, 2'b00, 1'b0, 1'b1);
    tick(); chk_all("t00.E4", 3'b111, 2'b01, 1'b0, 1'b0);
    tick(); chk_all("t00.park", 3'b111, 2'b01, 1'b0, 1'b0);

    // start held high through a target 01 request, target changing
    start = 1'b1; target = 2'b01;
    tick(); target = 2'b00;
    chk_all("t01.E", 3'b101, 2'b01, 1'b1, 1'b0);
    tick(); target = 2'b10;
    chk_all("t01.E1", 3'b000, 2'b11, 1'b1, 1'b0);
    tick(); chk_all("t01.E2", 3'b111, 2'b01, 1'b0, 1'b1);
    tick(); start = 1'b0; target = 2'b00;
    chk_all("b2b.E", 3'b101, 2'b01, 1'b1, 1'b0);
    tick(); chk_all("b2b.E1", 3'b011, 2'b11, 1'b1, 1'b0);
    tick(); chk_all("b2b.E2", 3'b100, 2'b10, 1'b0, 1'b1);
    tick(); chk_all("b2b.park", 3'b100, 2'b10, 1'b0, 1'b0);

    // reset while in STEP1 of a target 00 request
    start = 1'b1; target = 2'b00;
    tick(); start = 1'b0;
    tick(); chk_all("rs.step1", 3'b000, 2'b11, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk_all("rs.E", 3'b101, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("rs.after", 3'b101, 2'b11, 1'b0, 1'b0);
    end

    // corrupted observation while state is 11
    force_q1_low = 1'b1;
    tick(); force_q1_low = 1'b0;
`ifdef IC1406_DRIVER_CHECK_EN
    chk("err.set", {7'd0, error}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err.sticky", {7'd0, error}, 8'd1);
    end
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("err.clear", {7'd0, error}, 8'd0);
`else
    chk("err.tied", {7'd0, error}, 8'd0);
    tick();
    chk("err.tied2", {7'd0, error}, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
